// File: rtl/pulse_seq_pkg.sv
// Shared encodings for the pulse sequence generator: rate modes, schedule FSM
// states and the preset half-period calculation.
package pulse_seq_pkg;

    typedef enum logic [1:0] {
        MODE_32HZ  = 2'd0,
        MODE_64HZ  = 2'd1,
        MODE_128HZ = 2'd2,
        MODE_SEQ   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Half-period in clock cycles for a fixed rate; a full period is twice this.
    function automatic int unsigned preset_half(input int unsigned clk_hz, input mode_e mode);
        case (mode)
            MODE_32HZ:  return clk_hz / 64;
            MODE_64HZ:  return clk_hz / 128;
            MODE_128HZ: return clk_hz / 256;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/pulse_seq_gen_rate_divider.sv
// Half-period divider: toggles a phase every `half` enabled cycles and strobes
// on each low-to-high phase transition. New half-periods land only on toggles.
module rate_divider #(
    parameter int CNT_W      = 32,
    parameter bit IDLE_PHASE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W-1:0] half,
    output logic             phase,
    output logic             rise
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             phase_q, phase_d;
    logic             rise_q, rise_d;

    // A zero half_q marks the divider idle, so the next requested half is taken at once.
    always_comb begin
        cnt_d   = cnt_q;
        half_d  = half_q;
        phase_d = phase_q;
        rise_d  = 1'b0;
        if (restart) begin
            cnt_d   = '0;
            half_d  = half;
            phase_d = IDLE_PHASE;
        end else if (!en) begin
            cnt_d   = '0;
            half_d  = '0;
            phase_d = IDLE_PHASE;
        end else if (half_q == '0) begin
            cnt_d   = '0;
            half_d  = half;
            phase_d = IDLE_PHASE;
        end else if (cnt_q == half_q - ONE) begin
            cnt_d   = '0;
            half_d  = half;
            phase_d = (half == '0) ? IDLE_PHASE : ~phase_q;
            rise_d  = ~phase_q & phase_d;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            half_q  <= '0;
            phase_q <= IDLE_PHASE;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            rise_q  <= rise_d;
        end
    end

    assign phase = phase_q;
    assign rise  = rise_q;

endmodule

// File: rtl/pulse_seq_gen.sv
// Stepper pulse generator: three preset rates or a programmable rate/duration
// schedule, plus a 1 Hz strobe and a wrapping rising-edge counter.
module pulse_seq_gen
    import pulse_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int          CNT_W     = 32,
    parameter int          SEQ_DEPTH = 16,
    parameter int          PCNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic                         seq_wr_en,
    input  logic [$clog2(SEQ_DEPTH)-1:0] seq_wr_addr,
    input  logic [CNT_W-1:0]             seq_wr_half,
    input  logic [7:0]                   seq_wr_secs,
    input  logic                         pcnt_clr,
    output logic                         pulse,
    output logic                         pulse_rise,
    output logic                         tick_1hz,
    output logic [$clog2(SEQ_DEPTH)-1:0] seq_idx,
    output logic                         seq_done,
    output logic [PCNT_W-1:0]            pulse_cnt
);

    localparam int IDX_W = $clog2(SEQ_DEPTH);
    localparam logic [CNT_W-1:0] HALF_32   = CNT_W'(preset_half(CLK_HZ, MODE_32HZ));
    localparam logic [CNT_W-1:0] HALF_64   = CNT_W'(preset_half(CLK_HZ, MODE_64HZ));
    localparam logic [CNT_W-1:0] HALF_128  = CNT_W'(preset_half(CLK_HZ, MODE_128HZ));
    localparam logic [CNT_W-1:0] TICK_HALF = CNT_W'(CLK_HZ / 2);

    logic [CNT_W-1:0] tbl_half_q [SEQ_DEPTH];
    logic [7:0]       tbl_secs_q [SEQ_DEPTH];

    seq_state_e       state_q;
    logic [IDX_W-1:0] seq_idx_q;
    logic             seq_done_q;
    logic [CNT_W-1:0] cur_half_q;
    logic [7:0]       secs_left_q;
    logic [PCNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

    logic             seq_go, tick_restart, tick_rise, tick_phase;
    logic             div_en, div_phase, div_rise, in_done, last_entry;
    logic [IDX_W-1:0] next_idx;
    logic [CNT_W-1:0] div_half;

    assign seq_go       = start && (mode == MODE_SEQ);
    assign tick_restart = (state_q == ST_IDLE) && seq_go && (tbl_secs_q[0] != 8'd0);
    assign next_idx     = seq_idx_q + IDX_W'(1);
    assign last_entry   = (seq_idx_q == IDX_W'(SEQ_DEPTH - 1));
    assign in_done      = (state_q == ST_DONE);
    assign div_en       = start && ((mode != MODE_SEQ) || (state_q == ST_RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEQ_DEPTH; i++) begin
                tbl_half_q[i] <= '0;
                tbl_secs_q[i] <= '0;
            end
        end else if (seq_wr_en) begin
            tbl_half_q[seq_wr_addr] <= seq_wr_half;
            tbl_secs_q[seq_wr_addr] <= seq_wr_secs;
        end
    end

    // Schedule sequencer; entries are read from the table only at load time.
    always_ff @(posedge clk) begin
        if (rst || !seq_go) begin
            state_q     <= ST_IDLE;
            seq_idx_q   <= '0;
            seq_done_q  <= 1'b0;
            cur_half_q  <= '0;
            secs_left_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tbl_secs_q[0] == 8'd0) begin
                        state_q    <= ST_DONE;
                        seq_done_q <= 1'b1;
                    end else begin
                        state_q     <= ST_RUN;
                        seq_idx_q   <= '0;
                        cur_half_q  <= tbl_half_q[0];
                        secs_left_q <= tbl_secs_q[0];
                    end
                end
                ST_RUN: begin
                    if (tick_rise) begin
                        if (secs_left_q == 8'd1) begin
                            if (last_entry || (tbl_secs_q[next_idx] == 8'd0)) begin
                                state_q    <= ST_DONE;
                                seq_done_q <= 1'b1;
                                cur_half_q <= '0;
                            end else begin
                                seq_idx_q   <= next_idx;
                                cur_half_q  <= tbl_half_q[next_idx];
                                secs_left_q <= tbl_secs_q[next_idx];
                            end
                        end else begin
                            secs_left_q <= secs_left_q - 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (mode)
            MODE_32HZ:  div_half = HALF_32;
            MODE_64HZ:  div_half = HALF_64;
            MODE_128HZ: div_half = HALF_128;
            default:    div_half = (state_q == ST_RUN) ? cur_half_q : '0;
        endcase
    end

    rate_divider #(.CNT_W(CNT_W), .IDLE_PHASE(1'b0)) u_pulse_div (
        .clk     (clk),
        .rst     (rst),
        .en      (div_en),
        .restart (1'b0),
        .half    (div_half),
        .phase   (div_phase),
        .rise    (div_rise)
    );

    // Idle phase high makes the first strobe after a restart land a full second later.
    rate_divider #(.CNT_W(CNT_W), .IDLE_PHASE(1'b1)) u_tick_div (
        .clk     (clk),
        .rst     (rst),
        .en      (1'b1),
        .restart (tick_restart),
        .half    (TICK_HALF),
        .phase   (tick_phase),
        .rise    (tick_rise)
    );

    always_comb begin
        pulse_cnt_d = pcnt_clr ? '0 : pulse_cnt_q + PCNT_W'(pulse_rise);
    end

    always_ff @(posedge clk) begin
        if (rst) pulse_cnt_q <= '0;
        else     pulse_cnt_q <= pulse_cnt_d;
    end

    assign pulse      = div_phase & ~in_done;
    assign pulse_rise = div_rise & ~in_done;
    assign tick_1hz   = tick_rise & tick_phase;
    assign seq_idx    = seq_idx_q;
    assign seq_done   = seq_done_q;
    assign pulse_cnt  = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Directed bench for pulse_seq_gen at CLK_HZ=1000; a second instance with a
// 4-bit pulse counter shares all inputs to observe counter wrap.
module tb_pulse_seq_gen;

    logic        clk = 1'b0;
    logic        rst, start, seq_wr_en, pcnt_clr;
    logic [1:0]  mode;
    logic [3:0]  seq_wr_addr;
    logic [15:0] seq_wr_half;
    logic [7:0]  seq_wr_secs;

    logic        pulse, pulse_rise, tick_1hz, seq_done;
    logic [3:0]  seq_idx;
    logic [15:0] pulse_cnt;

    logic        pulse_b, pulse_rise_b, tick_1hz_b, seq_done_b;
    logic [3:0]  seq_idx_b;
    logic [3:0]  pulse_cnt_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pulse_seq_gen #(.CLK_HZ(1000), .CNT_W(16), .SEQ_DEPTH(16), .PCNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .seq_wr_en(seq_wr_en), .seq_wr_addr(seq_wr_addr),
        .seq_wr_half(seq_wr_half), .seq_wr_secs(seq_wr_secs),
        .pcnt_clr(pcnt_clr), .pulse(pulse), .pulse_rise(pulse_rise),
        .tick_1hz(tick_1hz), .seq_idx(seq_idx), .seq_done(seq_done),
        .pulse_cnt(pulse_cnt)
    );

    pulse_seq_gen #(.CLK_HZ(1000), .CNT_W(16), .SEQ_DEPTH(16), .PCNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .seq_wr_en(seq_wr_en), .seq_wr_addr(seq_wr_addr),
        .seq_wr_half(seq_wr_half), .seq_wr_secs(seq_wr_secs),
        .pcnt_clr(pcnt_clr), .pulse(pulse_b), .pulse_rise(pulse_rise_b),
        .tick_1hz(tick_1hz_b), .seq_idx(seq_idx_b), .seq_done(seq_done_b),
        .pulse_cnt(pulse_cnt_b)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [15:0] h, input logic [7:0] s);
        seq_wr_addr = a;
        seq_wr_half = h;
        seq_wr_secs = s;
        seq_wr_en   = 1'b1;
        step();
        seq_wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 2'd0; seq_wr_en = 1'b0; pcnt_clr = 1'b0;
        seq_wr_addr = '0; seq_wr_half = '0; seq_wr_secs = '0;
        step(); step();
        checks++; if (pulse !== 1'b0) $display("[TB] FAIL reset_pulse: got %b expected 0", pulse); else passes++;
        checks++; if (pulse_rise !== 1'b0) $display("[TB] FAIL reset_rise: got %b expected 0", pulse_rise); else passes++;
        checks++; if (tick_1hz !== 1'b0) $display("[TB] FAIL reset_tick: got %b expected 0", tick_1hz); else passes++;
        checks++; if (seq_idx !== 4'd0) $display("[TB] FAIL reset_idx: got %0d expected 0", seq_idx); else passes++;
        checks++; if (seq_done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", seq_done); else passes++;
        checks++; if (pulse_cnt !== 16'd0) $display("[TB] FAIL reset_cnt: got %0d expected 0", pulse_cnt); else passes++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_mode0();
        int rises = 0, first = -1, second = -1;
        mode = 2'd0; start = 1'b1;
        for (int n = 0; n <= 470; n++) begin
            step();
            if (pulse_rise === 1'b1) begin
                if (rises == 0) first = n;
                else if (rises == 1) second = n;
                rises++;
            end
            if (n == 20) begin
                checks++; if (pulse !== 1'b1) $display("[TB] FAIL m0_high_phase: got %b expected 1", pulse); else passes++;
            end
            if (n == 35) begin
                checks++; if (pulse !== 1'b0) $display("[TB] FAIL m0_low_phase: got %b expected 0", pulse); else passes++;
            end
            if (n == 290) begin
                checks++; if (pulse_cnt !== 16'd10) $display("[TB] FAIL m0_cnt10: got %0d expected 10", pulse_cnt); else passes++;
            end
            if (n == 440) begin
                checks++; if (pulse_cnt_b !== 4'd15) $display("[TB] FAIL wrap_cnt15: got %0d expected 15", pulse_cnt_b); else passes++;
            end
            if (n == 470) begin
                checks++; if (pulse_cnt_b !== 4'd0) $display("[TB] FAIL wrap_to0: got %0d expected 0", pulse_cnt_b); else passes++;
                checks++; if (pulse_cnt !== 16'd16) $display("[TB] FAIL m0_cnt16: got %0d expected 16", pulse_cnt); else passes++;
            end
        end
        checks++; if (first != 15) $display("[TB] FAIL m0_first_rise: got %0d expected 15", first); else passes++;
        checks++; if (second != 45) $display("[TB] FAIL m0_second_rise: got %0d expected 45", second); else passes++;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int highs = 0, first = -1;
        for (int k = 0; k < 60 && !found; k++) begin
            step();
            if (pulse === 1'b1) found = 1;
        end
        checks++; if (!found) $display("[TB] FAIL rstmid_wait_high: got timeout expected pulse high"); else passes++;
        rst = 1'b1; start = 1'b0;
        step();
        checks++; if (pulse !== 1'b0) $display("[TB] FAIL rstmid_pulse: got %b expected 0", pulse); else passes++;
        checks++; if (pulse_cnt !== 16'd0) $display("[TB] FAIL rstmid_cnt: got %0d expected 0", pulse_cnt); else passes++;
        checks++; if (pulse_cnt_b !== 4'd0) $display("[TB] FAIL rstmid_cnt4: got %0d expected 0", pulse_cnt_b); else passes++;
        checks++; if (tick_1hz !== 1'b0) $display("[TB] FAIL rstmid_tick: got %b expected 0", tick_1hz); else passes++;
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (pulse === 1'b1) highs++;
        end
        checks++; if (highs != 0) $display("[TB] FAIL rstmid_stays_low: got %0d high cycles expected 0", highs); else passes++;
        start = 1'b1;
        for (int n = 0; n < 40 && first < 0; n++) begin
            step();
            if (pulse_rise === 1'b1) first = n;
        end
        checks++; if (first != 15) $display("[TB] FAIL rstmid_restart_rise: got %0d expected 15", first); else passes++;
        start = 1'b0;
        step();
    endtask

    task automatic test_rate_change();
        bit found = 0;
        int hi = 1, lo = 1, hi2 = 1;
        mode = 2'd2; start = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (pulse_rise === 1'b1) found = 1;
        end
        checks++; if (!found) $display("[TB] FAIL rate_wait_rise: got timeout expected rise"); else passes++;
        mode = 2'd0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (pulse === 1'b1) hi++; else break;
        end
        for (int k = 0; k < 40; k++) begin
            step();
            if (pulse === 1'b0) lo++; else break;
        end
        for (int k = 0; k < 40; k++) begin
            step();
            if (pulse === 1'b1) hi2++; else break;
        end
        checks++; if (hi != 3) $display("[TB] FAIL rate_old_phase: got %0d expected 3", hi); else passes++;
        checks++; if (lo != 15) $display("[TB] FAIL rate_new_low: got %0d expected 15", lo); else passes++;
        checks++; if (hi2 != 15) $display("[TB] FAIL rate_new_high: got %0d expected 15", hi2); else passes++;
        start = 1'b0;
        step();
    endtask

    task automatic test_clear();
        bit found = 0;
        mode = 2'd0; start = 1'b1;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (pulse_rise === 1'b1) found = 1;
        end
        checks++; if (!found) $display("[TB] FAIL clr_wait_rise: got timeout expected rise"); else passes++;
        pcnt_clr = 1'b1;
        step();
        pcnt_clr = 1'b0;
        checks++; if (pulse_cnt !== 16'd0) $display("[TB] FAIL clr_wins: got %0d expected 0", pulse_cnt); else passes++;
        checks++; if (pulse_cnt_b !== 4'd0) $display("[TB] FAIL clr_wins4: got %0d expected 0", pulse_cnt_b); else passes++;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (pulse_rise === 1'b1) found = 1;
        end
        step();
        checks++; if (pulse_cnt !== 16'd1) $display("[TB] FAIL clr_then_count: got %0d expected 1", pulse_cnt); else passes++;
        start = 1'b0;
        step();
    endtask

    task automatic test_schedule();
        int rises = 0, late = 0, r1 = -1, r2 = -1, first_tick = -1;
        logic [15:0] exp_cnt;
        mode = 2'd3; start = 1'b0;
        write_entry(4'd0, 16'd5, 8'd2);
        write_entry(4'd1, 16'd0, 8'd1);
        write_entry(4'd2, 16'd0, 8'd0);
        exp_cnt = pulse_cnt + 16'd200;
        start = 1'b1;
        for (int n = 0; n <= 3005; n++) begin
            step();
            if (tick_1hz === 1'b1 && first_tick < 0) first_tick = n;
            if (pulse_rise === 1'b1) begin
                if (n <= 2000) begin
                    if (rises == 0) r1 = n;
                    else if (rises == 1) r2 = n;
                    rises++;
                end else late++;
            end
            if (n == 2000) begin
                checks++; if (seq_idx !== 4'd0) $display("[TB] FAIL sch_idx_before: got %0d expected 0", seq_idx); else passes++;
            end
            if (n == 2001) begin
                checks++; if (seq_idx !== 4'd1) $display("[TB] FAIL sch_idx_advance: got %0d expected 1", seq_idx); else passes++;
            end
            if (n == 2500) begin
                checks++; if (pulse !== 1'b0) $display("[TB] FAIL sch_hold_low: got %b expected 0", pulse); else passes++;
            end
            if (n == 2990) begin
                checks++; if (seq_done !== 1'b0) $display("[TB] FAIL sch_done_early: got %b expected 0", seq_done); else passes++;
            end
            if (n == 3001) begin
                checks++; if (seq_done !== 1'b1) $display("[TB] FAIL sch_done: got %b expected 1", seq_done); else passes++;
            end
        end
        checks++; if (first_tick != 1000) $display("[TB] FAIL sch_first_tick: got %0d expected 1000", first_tick); else passes++;
        checks++; if (rises != 200) $display("[TB] FAIL sch_rise_count: got %0d expected 200", rises); else passes++;
        checks++; if (r2 - r1 != 10) $display("[TB] FAIL sch_period: got %0d expected 10", r2 - r1); else passes++;
        checks++; if (late != 0) $display("[TB] FAIL sch_late_rises: got %0d expected 0", late); else passes++;
        checks++; if (pulse_cnt !== exp_cnt) $display("[TB] FAIL sch_pulse_cnt: got %0d expected %0d", pulse_cnt, exp_cnt); else passes++;
        start = 1'b0;
        step();
    endtask

    task automatic test_depth_abort();
        mode = 2'd3; start = 1'b0;
        for (int i = 0; i < 16; i++) write_entry(4'(i), 16'd2, 8'd1);
        start = 1'b1;
        for (int n = 0; n <= 16003; n++) begin
            step();
            if (n == 15990) begin
                checks++; if (seq_idx !== 4'd15) $display("[TB] FAIL depth_last_idx: got %0d expected 15", seq_idx); else passes++;
                checks++; if (seq_done !== 1'b0) $display("[TB] FAIL depth_done_early: got %b expected 0", seq_done); else passes++;
            end
            if (n == 16001) begin
                checks++; if (seq_done !== 1'b1) $display("[TB] FAIL depth_done: got %b expected 1", seq_done); else passes++;
            end
            if (n == 16003) begin
                checks++; if (pulse !== 1'b0) $display("[TB] FAIL depth_done_pulse: got %b expected 0", pulse); else passes++;
            end
        end
        start = 1'b0;
        step();
        checks++; if (seq_done !== 1'b0) $display("[TB] FAIL depth_idle_done: got %b expected 0", seq_done); else passes++;
        start = 1'b1;
        for (int n = 0; n <= 1500; n++) begin
            step();
            if (n == 1500) begin
                checks++; if (seq_idx !== 4'd1) $display("[TB] FAIL abort_mid_idx: got %0d expected 1", seq_idx); else passes++;
            end
        end
        start = 1'b0;
        step();
        checks++; if (seq_idx !== 4'd0) $display("[TB] FAIL abort_idx: got %0d expected 0", seq_idx); else passes++;
        checks++; if (pulse !== 1'b0) $display("[TB] FAIL abort_pulse: got %b expected 0", pulse); else passes++;
        checks++; if (seq_done !== 1'b0) $display("[TB] FAIL abort_done: got %b expected 0", seq_done); else passes++;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_reset_mid();
        test_rate_change();
        test_clear();
        test_schedule();
        test_depth_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
